// File: rtl/max_pool2x2_stream.sv
// rtl/max_pool2x2_stream.sv - streaming 2x2 stride-2 signed max-pooling stage
//
// Purpose:
//   Takes one feature-map pixel per cycle in raster order. It emits one pooled
//   pixel per 2x2 window. Horizontal-pair maxima from each even row are kept in
//   a half-row line buffer. They are combined with the matching pair on the
//   following odd row, so no full frame is ever stored.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   in_valid    input pixel valid
//   in_ready    block can accept an input pixel this cycle
//   in_data     signed input pixel (DATA_W)
//   out_valid   pooled pixel valid
//   out_ready   downstream accepts the pooled pixel
//   out_data    signed pooled pixel (DATA_W)
//   out_last    marks the last pooled pixel of the frame
//   frame_done  one-cycle pulse following acceptance of the out_last pixel

module max_pool2x2_stream #(
    parameter int DATA_W  = 8,
    parameter int IMG_W   = 28,
    parameter int IMG_H   = 28,
    parameter bit RELU_EN = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              frame_done
);

    localparam int CW       = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW       = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int IW       = (IMG_W > 2) ? $clog2(IMG_W / 2) : 1;
    localparam int LB_DEPTH = 1 << IW;

    logic [CW-1:0]     col_q, col_d;
    logic [RW-1:0]     row_q, row_d;
    logic [DATA_W-1:0] pair_q;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q;
    logic              out_last_q;
    logic              frame_done_q;

    // Line buffer is not reset: every entry is written on an even row before
    // the odd row below it reads it back.
    logic [DATA_W-1:0] line_buf [LB_DEPTH];

    logic              in_xfer;
    logic              load;
    logic              last_pix;
    logic [IW-1:0]     lb_idx;
    logic [DATA_W-1:0] lb_rd;
    logic [DATA_W-1:0] h_max;
    logic [DATA_W-1:0] v_max;
    logic [DATA_W-1:0] result;

    // A single output register, so the input may advance only when that
    // register is empty or is being drained in the same cycle.
    assign in_ready = !out_valid_q || out_ready;
    assign in_xfer  = in_valid && in_ready;
    assign load     = in_xfer && col_q[0] && row_q[0];
    assign last_pix = (row_q == RW'(IMG_H - 1)) && (col_q == CW'(IMG_W - 1));
    assign lb_idx   = IW'(col_q >> 1);
    assign lb_rd    = line_buf[lb_idx];

    assign h_max  = ($signed(in_data) > $signed(pair_q)) ? in_data : pair_q;
    assign v_max  = ($signed(h_max) > $signed(lb_rd)) ? h_max : lb_rd;
    assign result = (RELU_EN && v_max[DATA_W-1]) ? '0 : v_max;

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (in_xfer) begin
            if (col_q == CW'(IMG_W - 1)) begin
                col_d = '0;
                row_d = (row_q == RW'(IMG_H - 1)) ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    // A new result may load while the old one is being accepted. That keeps
    // out_valid high, so the stage runs at full throughput.
    assign out_valid_d = load || (out_valid_q && !out_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q        <= '0;
            row_q        <= '0;
            pair_q       <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_last_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            out_valid_q  <= out_valid_d;
            frame_done_q <= out_valid_q && out_ready && out_last_q;
            if (in_xfer && !col_q[0]) begin
                pair_q <= in_data;
            end
            if (load) begin
                out_data_q <= result;
                out_last_q <= last_pix;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (in_xfer && col_q[0] && !row_q[0]) begin
            line_buf[lb_idx] <= h_max;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_last   = out_last_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_max_pool2x2_stream.sv
// tb/tb_max_pool2x2_stream.sv - self-checking bench for max_pool2x2_stream

module tb_max_pool2x2_stream;

    logic       clk;
    logic       rst_n;
    logic       iv;
    logic [7:0] id;
    logic       ordy;
    logic [2:0] ird;
    logic [2:0] ov;
    logic [2:0] ol;
    logic [2:0] fd;
    logic [7:0] od [3];

    int checks;
    int errors;
    int cyc;

    int px_q   [3][$];
    int exp_q  [3][$];
    int got    [3][$];
    int stamp  [3][$];
    int frames [3];
    int fd_cnt [3];
    int out_cnt[3];
    int acc_cnt[3];
    int pushed [3];
    int stall  [3];
    bit last_acc[3];

    // k=0: 4x4 pass-through, k=1: 4x4 with ReLU, k=2: 28x28 pass-through
    max_pool2x2_stream #(.DATA_W(8), .IMG_W(4), .IMG_H(4), .RELU_EN(1'b0)) u_small (
        .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ird[0]), .in_data(id),
        .out_valid(ov[0]), .out_ready(ordy), .out_data(od[0]), .out_last(ol[0]),
        .frame_done(fd[0]));

    max_pool2x2_stream #(.DATA_W(8), .IMG_W(4), .IMG_H(4), .RELU_EN(1'b1)) u_relu (
        .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ird[1]), .in_data(id),
        .out_valid(ov[1]), .out_ready(ordy), .out_data(od[1]), .out_last(ol[1]),
        .frame_done(fd[1]));

    max_pool2x2_stream #(.DATA_W(8), .IMG_W(28), .IMG_H(28), .RELU_EN(1'b0)) u_big (
        .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ird[2]), .in_data(id),
        .out_valid(ov[2]), .out_ready(ordy), .out_data(od[2]), .out_last(ol[2]),
        .frame_done(fd[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    function automatic int gw(int k);
        return (k == 2) ? 28 : 4;
    endfunction

    task automatic check(string tag, int obs, int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int k = 0; k < 3; k++) begin
            px_q[k].delete();
            exp_q[k].delete();
            got[k].delete();
            stamp[k].delete();
            frames[k]   = 0;
            fd_cnt[k]   = 0;
            out_cnt[k]  = 0;
            acc_cnt[k]  = 0;
            pushed[k]   = 0;
            stall[k]    = 0;
            last_acc[k] = 1'b0;
        end
    endtask

    // Reference: each instance keeps the pixels of its current frame. When the
    // bottom-right pixel of a 2x2 window arrives, the window maximum is taken
    // from the stored frame. Expected entries are encoded as value*2 + last.
    task automatic monitor();
        int w, p, r, c, m, n;
        int obs;
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) last_acc[k] = 1'b0;
            return;
        end
        for (int k = 0; k < 3; k++) begin
            if (fd[k] || last_acc[k])
                check($sformatf("frame_done_timing_%0d", k), int'(fd[k]), int'(last_acc[k]));
            if (fd[k]) fd_cnt[k]++;
            last_acc[k] = ov[k] && ordy && ol[k];
            if (ov[k] && ordy) begin
                obs = $signed(od[k]) * 2 + int'(ol[k]);
                if (exp_q[k].size() == 0) begin
                    check($sformatf("unexpected_out_%0d", k), obs, -9999);
                end else begin
                    check($sformatf("out_%0d", k), obs, exp_q[k].pop_front());
                end
                got[k].push_back($signed(od[k]));
                stamp[k].push_back(cyc);
                out_cnt[k]++;
            end
            if (iv && !ird[k]) stall[k]++;
            if (iv && ird[k]) begin
                acc_cnt[k]++;
                px_q[k].push_back($signed(id));
                w = gw(k);
                n = px_q[k].size();
                p = n - 1;
                r = p / w;
                c = p % w;
                if ((r % 2 == 1) && (c % 2 == 1)) begin
                    m = px_q[k][p];
                    if (px_q[k][p-1] > m)     m = px_q[k][p-1];
                    if (px_q[k][p-w] > m)     m = px_q[k][p-w];
                    if (px_q[k][p-w-1] > m)   m = px_q[k][p-w-1];
                    if (k == 1 && m < 0)      m = 0;
                    exp_q[k].push_back(m * 2 + ((n == w * w) ? 1 : 0));
                    pushed[k]++;
                end
                if (n == w * w) begin
                    px_q[k].delete();
                    frames[k]++;
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            monitor();
        end
    end

    task automatic do_reset();
        iv    = 1'b0;
        ordy  = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rst_out_valid_%0d", k), int'(ov[k]), 0);
            check($sformatf("rst_out_data_%0d", k), int'(od[k]), 0);
            check($sformatf("rst_out_last_%0d", k), int'(ol[k]), 0);
            check($sformatf("rst_frame_done_%0d", k), int'(fd[k]), 0);
            check($sformatf("rst_in_ready_%0d", k), int'(ird[k]), 1);
        end
        clear_model();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    int t2 [16];
    int ramp_exp [4];
    int held;
    int n0;
    int guard;

    initial begin
        checks = 0;
        errors = 0;
        iv     = 1'b0;
        id     = '0;
        ordy   = 1'b1;
        rst_n  = 1'b0;
        clear_model();
        do_reset();

        // Ramp 0..15 at full rate into the 4x4 instances
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            iv = 1'b1;
            id = 8'(i);
        end
        @(posedge clk); #1;
        iv = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        ramp_exp = '{5, 7, 13, 15};
        check("ramp_count", got[0].size(), 4);
        if (got[0].size() == 4) begin
            for (int i = 0; i < 4; i++) check($sformatf("ramp_val_%0d", i), got[0][i], ramp_exp[i]);
            check("ramp_gap_row1", stamp[0][1] - stamp[0][0], 2);
            check("ramp_gap_row3", stamp[0][3] - stamp[0][2], 2);
        end
        check("ramp_frame_done", fd_cnt[0], 1);
        check("ramp_no_stall", stall[0], 0);
        check("ramp_accepts", acc_cnt[0], 16);

        // Negative windows, with and without ReLU
        do_reset();
        t2 = '{-128, -3, -128, -128, -100, -7, -128, -128, 0, 0, 0, 0, 0, 0, 0, 0};
        for (int i = 8; i < 16; i++) t2[i] = $signed(8'($urandom));
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            iv = 1'b1;
            id = 8'(t2[i]);
        end
        @(posedge clk); #1;
        iv = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("neg_count", got[0].size(), 4);
        check("neg_relu_count", got[1].size(), 4);
        if (got[0].size() >= 2 && got[1].size() >= 2) begin
            check("neg_window", got[0][0], -3);
            check("neg_window_relu", got[1][0], 0);
            check("min_window", got[0][1], -128);
            check("min_window_relu", got[1][1], 0);
        end

        // Backpressure: hold out_ready low while a result is pending
        do_reset();
        ordy  = 1'b0;
        guard = 0;
        forever begin
            @(posedge clk); #1;
            if (ov[0] || guard >= 100) break;
            iv = 1'b1;
            id = 8'($urandom);
            guard++;
        end
        check("hold_result_seen", int'(ov[0]), 1);
        held = int'(od[0]);
        n0   = acc_cnt[0];
        repeat (5) begin
            @(negedge clk);
            check("hold_in_ready", int'(ird[0]), 0);
            check("hold_out_valid", int'(ov[0]), 1);
            check("hold_out_data", int'(od[0]), held);
        end
        check("hold_no_consume", acc_cnt[0], n0);
        @(posedge clk); #1;
        ordy = 1'b1;
        repeat (30) begin
            @(posedge clk); #1;
            iv = 1'b1;
            id = 8'($urandom);
        end
        iv = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("hold_no_loss", out_cnt[0], pushed[0]);

        // Three back-to-back 28x28 frames with random gaps and backpressure
        do_reset();
        guard = 0;
        forever begin
            @(posedge clk); #1;
            if (frames[2] >= 3 || guard >= 40000) break;
            iv   = ($urandom % 4) != 0;
            id   = 8'($urandom);
            ordy = ($urandom % 4) != 0;
            guard++;
        end
        iv   = 1'b0;
        ordy = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("rand_frames", frames[2], 3);
        check("rand_results", out_cnt[2], 588);
        check("rand_frame_done", fd_cnt[2], 3);
        check("rand_drained", exp_q[2].size(), 0);

        // Asynchronous reset in row 3, then a fresh frame
        do_reset();
        guard = 0;
        forever begin
            @(posedge clk); #1;
            if (px_q[2].size() >= 3 * 28 + 10 || guard >= 10000) break;
            iv   = ($urandom % 4) != 0;
            id   = 8'($urandom);
            ordy = ($urandom % 2) != 0;
            guard++;
        end
        check("midreset_reached_row3", px_q[2].size(), 3 * 28 + 10);
        #2;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) check($sformatf("async_rst_valid_%0d", k), int'(ov[k]), 0);
        iv   = 1'b0;
        ordy = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        clear_model();
        rst_n = 1'b1;
        guard = 0;
        forever begin
            @(posedge clk); #1;
            if (frames[2] >= 1 || guard >= 2000) break;
            iv = 1'b1;
            id = 8'($urandom);
            guard++;
        end
        iv = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("fresh_results", out_cnt[2], 196);
        check("fresh_frame_done", fd_cnt[2], 1);
        check("fresh_drained", exp_q[2].size(), 0);
        check("fresh_no_stall", stall[2], 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
